led_seq_ctrl: RTL and testbench

//  Run/pause/direction/speed controller for the 6-LED bar-graph pattern path.

---
 rtl/led_seq_pkg.sv | 21 ++
 rtl/led_seq_ctrl_btn_debounce.sv | 47 ++++
 rtl/led_seq_ctrl.sv | 106 ++++++++++
 tb/tb_led_seq_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// Shared state encodings, speed-select codes and step-period helper for the LED sequencer.
// Pure definitions; no logic.
package led_seq_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;

  localparam logic [1:0] SPD_X1 = 2'd0;
  localparam logic [1:0] SPD_X2 = 2'd1;
  localparam logic [1:0] SPD_X4 = 2'd2;
  localparam logic [1:0] SPD_X8 = 2'd3;

  // Terminal prescaler count for a speed code; a zero-length period clamps to 0.
  function automatic logic [31:0] step_limit(input int unsigned div, input logic [1:0] spd);
    logic [31:0] w_period;
    w_period = 32'(div) >> spd;
    return (w_period == 32'd0) ? 32'd0 : w_period - 32'd1;
  endfunction

endpackage

// File: rtl/led_seq_ctrl_btn_debounce.sv
// Button conditioner: 2-FF synchroniser, stability counter, 1-cycle press pulse.
// Pulse appears DEB_CYCLES+2 cycles after a stable raw press; no backpressure.
module btn_debounce #(
  parameter int unsigned DEB_CYCLES = 270_000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn_n,
  output logic o_press
);

  localparam int unsigned   CW     = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] C_LAST = CW'(DEB_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_stable;
  logic [CW-1:0] r_cnt;
  logic          r_press;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_stable <= 1'b1;
      r_cnt    <= '0;
      r_press  <= 1'b0;
    end else begin
      r_sync1 <= i_btn_n;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      // Any sample matching the accepted level restarts the stability window.
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == C_LAST) begin
        r_cnt    <= '0;
        r_stable <= r_sync2;
        r_press  <= ~r_sync2;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/led_seq_ctrl.sv
// Run/pause/direction/speed sequencer producing the LED pattern step index.
// step_tick is registered alongside the new step_idx; buttons act one cycle after their press pulse.
module led_seq_ctrl #(
  parameter int unsigned TICK_DIV   = 13_500_000,
  parameter int unsigned N_STEPS    = 10,
  parameter int unsigned IDX_W      = 6,
  parameter int unsigned DEB_CYCLES = 270_000
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_btn_run_n,
  input  logic             i_btn_dir_n,
  input  logic [1:0]       i_spd,
  output logic [IDX_W-1:0] o_step_idx,
  output logic             o_step_tick,
  output logic             o_running,
  output logic             o_dir_up
);

  import led_seq_pkg::*;

  localparam int unsigned      PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_STEPS - 1);

  logic             w_run_press;
  logic             w_dir_press;
  logic [31:0]      w_limit;
  logic             w_hit;
  logic [IDX_W-1:0] w_idx_next;

  logic [1:0]       r_state;
  logic [PW-1:0]    r_presc;
  logic [IDX_W-1:0] r_idx;
  logic             r_tick;
  logic             r_dir;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_run (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_btn_n (i_btn_run_n),
    .o_press (w_run_press)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dir (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_btn_n (i_btn_dir_n),
    .o_press (w_dir_press)
  );

  // Greater-or-equal lets a speed increase that undercuts the count wrap at once.
  assign w_limit = step_limit(TICK_DIV, i_spd);
  assign w_hit   = (32'(r_presc) >= w_limit);

  always_comb begin
    w_idx_next = r_idx;
    if (r_dir) begin
      w_idx_next = (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
    end else begin
      w_idx_next = (r_idx == '0) ? IDX_LAST : r_idx - IDX_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_presc <= '0;
      r_idx   <= '0;
      r_tick  <= 1'b0;
      r_dir   <= 1'b1;
    end else begin
      r_tick <= 1'b0;
      if (w_dir_press) begin
        r_dir <= ~r_dir;
      end
      case (r_state)
        ST_IDLE: begin
          r_presc <= '0;
          if (w_run_press) r_state <= ST_RUN;
        end
        ST_RUN: begin
          // Pause beats a coincident step; the count is frozen for resume.
          if (w_run_press) begin
            r_state <= ST_PAUSE;
          end else if (w_hit) begin
            r_presc <= '0;
            r_idx   <= w_idx_next;
            r_tick  <= 1'b1;
          end else begin
            r_presc <= r_presc + PW'(1);
          end
        end
        ST_PAUSE: begin
          if (w_run_press) r_state <= ST_RUN;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_step_idx  = r_idx;
  assign o_step_tick = r_tick;
  assign o_running   = (r_state == ST_RUN);
  assign o_dir_up    = r_dir;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Randomised and directed bench for led_seq_ctrl against a rule-level reference model.
module tb_led_seq_ctrl;

  localparam int unsigned TICK_DIV = 8;
  localparam int unsigned N_STEPS  = 10;
  localparam int unsigned IDX_W    = 6;
  localparam int unsigned DEB      = 4;

  logic             clk       = 1'b0;
  logic             rst_n     = 1'b0;
  logic             btn_run_n = 1'b1;
  logic             btn_dir_n = 1'b1;
  logic [1:0]       spd       = 2'd0;
  logic [IDX_W-1:0] step_idx;
  logic             step_tick;
  logic             running;
  logic             dir_up;

  int n_cmp = 0;
  int n_bad = 0;

  led_seq_ctrl #(
    .TICK_DIV   (TICK_DIV),
    .N_STEPS    (N_STEPS),
    .IDX_W      (IDX_W),
    .DEB_CYCLES (DEB)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_btn_run_n (btn_run_n),
    .i_btn_dir_n (btn_dir_n),
    .i_spd       (spd),
    .o_step_idx  (step_idx),
    .o_step_tick (step_tick),
    .o_running   (running),
    .o_dir_up    (dir_up)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: debounced level is a sliding window over raw samples,
  // sequencer tracked as started/running flags with modular index arithmetic.
  int m_idx;
  int m_cnt;
  bit m_tick;
  bit m_started;
  bit m_running;
  bit m_dir;
  bit m_pend [2];
  bit m_acc  [2];
  bit m_hist [2][16];

  task automatic model_reset();
    m_idx = 0; m_cnt = 0; m_tick = 0;
    m_started = 0; m_running = 0; m_dir = 1;
    for (int b = 0; b < 2; b++) begin
      m_pend[b] = 0;
      m_acc[b]  = 1;
      for (int i = 0; i < 16; i++) m_hist[b][i] = 1;
    end
  endtask

  task automatic deb_step(input int b, input bit raw, output bit ev);
    bit flip;
    ev = 0;
    for (int i = 15; i > 0; i--) m_hist[b][i] = m_hist[b][i-1];
    m_hist[b][0] = raw;
    // Synchroniser delay of two: window covers samples 2..DEB+1 edges back.
    flip = 1;
    for (int i = 2; i <= DEB + 1; i++) if (m_hist[b][i] == m_acc[b]) flip = 0;
    if (flip) begin
      m_acc[b] = !m_acc[b];
      ev = !m_acc[b];
    end
  endtask

  task automatic model_edge();
    bit pr, pd, ev_run, ev_dir;
    int lim;
    if (!rst_n) begin
      model_reset();
      return;
    end
    pr = m_pend[0];
    pd = m_pend[1];
    deb_step(0, btn_run_n, ev_run);
    deb_step(1, btn_dir_n, ev_dir);
    lim = int'(TICK_DIV >> spd) - 1;
    if (lim < 0) lim = 0;
    m_tick = 0;
    if (m_running) begin
      if (pr) m_running = 0;
      else if (m_cnt >= lim) begin
        m_cnt  = 0;
        m_idx  = (m_idx + (m_dir ? 1 : N_STEPS - 1)) % N_STEPS;
        m_tick = 1;
      end else m_cnt++;
    end else if (!m_started) begin
      m_cnt = 0;
      if (pr) begin m_started = 1; m_running = 1; end
    end else if (pr) begin
      m_running = 1;
    end
    if (pd) m_dir = !m_dir;
    m_pend[0] = ev_run;
    m_pend[1] = ev_dir;
  endtask

  task automatic do_cycle(input string tag);
    logic [IDX_W-1:0] e_idx;
    @(posedge clk);
    model_edge();
    #1;
    e_idx = IDX_W'(m_idx);
    check(tag, {step_idx, step_tick, running, dir_up}, {e_idx, m_tick, m_running, m_dir});
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_idx"},     32'(step_idx), 32'd0);
    check({tag, "_tick"},    32'(step_tick), 32'd0);
    check({tag, "_running"}, 32'(running),  32'd0);
    check({tag, "_dir"},     32'(dir_up),   32'd1);
  endtask

  // Entered just after a sampling point; asserts reset between clock edges.
  task automatic mid_reset(input int hold);
    #3 rst_n = 1'b0;
    #1 check_reset_outs("async_rst");
    model_reset();
    repeat (hold) do_cycle("in_rst");
    rst_n = 1'b1;
  endtask

  initial begin
    int n_tick;
    int guard;
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_reset_outs("por");
    #2 rst_n = 1'b1;

    // Short glitch never survives the stability window.
    btn_run_n = 1'b0;
    repeat (3) do_cycle("glitch");
    btn_run_n = 1'b1;
    repeat (12) do_cycle("glitch_after");
    check("glitch_running", 32'(running), 32'd0);

    btn_run_n = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      do_cycle("run_press");
      if (k == 6) check("run_lat6", 32'(running), 32'd0);
      if (k == 7) check("run_lat7", 32'(running), 32'd1);
    end
    btn_run_n = 1'b1;
    n_tick = 0;
    repeat (90) begin
      do_cycle("seq");
      if (step_tick) begin
        n_tick++;
        if (n_tick == 10) check("wrap_to_0", 32'(step_idx), 32'd0);
      end
    end
    check("tick_count", n_tick, 32'd11);

    spd = 2'd3;
    repeat (5) do_cycle("spd3");
    check("spd3_tick", 32'(step_tick), 32'd1);
    spd = 2'd0;
    guard = 0;
    while (m_cnt != 6 && guard < 20) begin do_cycle("spd0"); guard++; end
    check("spd0_reach6", m_cnt, 32'd6);
    spd = 2'd2;
    do_cycle("spd2_wrap");
    check("spd2_wrap_tick", 32'(step_tick), 32'd1);
    do_cycle("spd2_a");
    check("spd2_gap", 32'(step_tick), 32'd0);
    do_cycle("spd2_b");
    check("spd2_period", 32'(step_tick), 32'd1);

    // Land the pause press exactly on a step edge.
    spd = 2'd0;
    guard = 0;
    while (!(m_running && m_cnt == 1) && guard < 20) begin do_cycle("align"); guard++; end
    check("align_cnt1", m_cnt, 32'd1);
    btn_run_n = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      do_cycle("pause_press");
      if (k == 7) begin
        check("pause_on_tick_run",  32'(running),   32'd0);
        check("pause_on_tick_tick", 32'(step_tick), 32'd0);
      end
    end
    btn_run_n = 1'b1;
    repeat (10) do_cycle("paused");
    btn_run_n = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      do_cycle("resume_press");
      if (k == 8) check("resume_held_count_tick", 32'(step_tick), 32'd1);
    end
    btn_run_n = 1'b1;

    repeat (5) do_cycle("pre_rst");
    mid_reset(2);

    for (int seg = 0; seg < 160; seg++) begin
      int op;
      int len;
      op  = $urandom_range(0, 9);
      len = $urandom_range(1, 12);
      if (op <= 2) begin
        btn_run_n = 1'b0;
        repeat (len) do_cycle("rnd_run");
        btn_run_n = 1'b1;
      end else if (op <= 5) begin
        btn_dir_n = 1'b0;
        repeat (len) do_cycle("rnd_dir");
        btn_dir_n = 1'b1;
      end else if (op <= 7) begin
        spd = 2'($urandom_range(0, 3));
      end else if (op == 9 && $urandom_range(0, 3) == 0) begin
        mid_reset($urandom_range(1, 3));
      end
      repeat ($urandom_range(0, 30)) do_cycle("rnd_wait");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
